// File: rtl/score_keeper_if.sv
// Game-event and scoreboard signal bundle for score_keeper.
// The master side drives game events; the slave side (score_keeper) publishes the score state.
interface score_keeper_if;
  logic        start_i;
  logic        spawn_i;
  logic        p1_kill_i;
  logic        p2_kill_i;
  logic [1:0]  p1_kill_type_i;
  logic [1:0]  p2_kill_type_i;
  logic        p1_hit_i;
  logic        p2_hit_i;
  logic [5:0]  tank_left_o;
  logic [3:0]  level_o;
  logic [10:0] player_1_score_o;
  logic [10:0] player_2_score_o;
  logic [3:0]  player_1_live_left_o;
  logic [3:0]  player_2_live_left_o;
  logic [1:0]  state_o;
  logic        game_won_o;
  logic        level_clear_o;

  modport master (
    output start_i, spawn_i, p1_kill_i, p2_kill_i, p1_kill_type_i, p2_kill_type_i,
           p1_hit_i, p2_hit_i,
    input  tank_left_o, level_o, player_1_score_o, player_2_score_o,
           player_1_live_left_o, player_2_live_left_o, state_o, game_won_o, level_clear_o
  );

  modport slave (
    input  start_i, spawn_i, p1_kill_i, p2_kill_i, p1_kill_type_i, p2_kill_type_i,
           p1_hit_i, p2_hit_i,
    output tank_left_o, level_o, player_1_score_o, player_2_score_o,
           player_1_live_left_o, player_2_live_left_o, state_o, game_won_o, level_clear_o
  );
endinterface

// File: rtl/score_keeper.sv
// Two-player tank game score/lives/level keeper with a registered game FSM.
// Optional feature: define SCORE_KEEPER_BONUS_LIFE_EN to grant a life per 500 points crossed.
module score_keeper #(
  parameter int START_LIVES     = 3,
  parameter int TANKS_PER_LEVEL = 20,
  parameter int CLEAR_DELAY     = 120
) (
  input logic           clk_i,
  input logic           rst_ni,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PLAY        = 2'd1,
    ST_LEVEL_CLEAR = 2'd2,
    ST_GAME_OVER   = 2'd3
  } state_t;

  localparam int                CNT_W      = (CLEAR_DELAY > 1) ? $clog2(CLEAR_DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLEAR_DELAY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [5:0]        TANKS_INIT = 6'(TANKS_PER_LEVEL);
  localparam logic [3:0]        LIVES_INIT = 4'(START_LIVES);

  state_t           r_state;
  logic [3:0]       r_level;
  logic [5:0]       r_tankLeft;
  logic [5:0]       r_alive;
  logic [10:0]      r_p1Score;
  logic [10:0]      r_p2Score;
  logic [3:0]       r_p1Lives;
  logic [3:0]       r_p2Lives;
  logic             r_gameWon;
  logic             r_levelClear;
  logic [CNT_W-1:0] r_delayCnt;

  logic        w_inPlay;
  logic        w_spawn;
  logic        w_p1Kill;
  logic        w_p2Kill;
  logic        w_p1Hit;
  logic        w_p2Hit;
  logic        w_p1Bonus;
  logic        w_p2Bonus;
  logic [10:0] w_p1ScoreNext;
  logic [10:0] w_p2ScoreNext;
  logic [3:0]  w_p1LivesNext;
  logic [3:0]  w_p2LivesNext;
  logic [5:0]  w_tankNext;
  logic [6:0]  w_aliveUp;
  logic [6:0]  w_aliveDec;
  logic [6:0]  w_aliveDiff;
  logic [5:0]  w_aliveNext;

  function automatic logic [5:0] killPoints(input logic [1:0] kind);
    case (kind)
      2'd0:    return 6'd10;
      2'd1:    return 6'd20;
      2'd2:    return 6'd30;
      default: return 6'd40;
    endcase
  endfunction

  function automatic logic [10:0] addScore(input logic [10:0] score, input logic [5:0] points);
    logic [11:0] sum;
    sum = {1'b0, score} + {6'b0, points};
    return (sum > 12'd2047) ? 11'd2047 : sum[10:0];
  endfunction

  // Net life change is applied first and then capped, so bonus and hit in one cycle cancel.
  function automatic logic [3:0] nextLives(input logic [3:0] lives, input logic hit,
                                           input logic bonus);
    logic [4:0] sum;
    sum = {1'b0, lives} + {4'b0, bonus} - {4'b0, hit};
    return (sum > 5'd9) ? 4'd9 : sum[3:0];
  endfunction

  always_comb begin
    w_inPlay      = (r_state == ST_PLAY);
    w_spawn       = w_inPlay && bus.spawn_i && (r_tankLeft != 6'd0);
    w_p1Kill      = w_inPlay && bus.p1_kill_i && (r_p1Lives != 4'd0);
    w_p2Kill      = w_inPlay && bus.p2_kill_i && (r_p2Lives != 4'd0);
    w_p1Hit       = w_inPlay && bus.p1_hit_i && (r_p1Lives != 4'd0);
    w_p2Hit       = w_inPlay && bus.p2_hit_i && (r_p2Lives != 4'd0);
    w_p1ScoreNext = w_p1Kill ? addScore(r_p1Score, killPoints(bus.p1_kill_type_i)) : r_p1Score;
    w_p2ScoreNext = w_p2Kill ? addScore(r_p2Score, killPoints(bus.p2_kill_type_i)) : r_p2Score;
`ifdef SCORE_KEEPER_BONUS_LIFE_EN
    w_p1Bonus     = w_p1Kill && ((r_p1Score / 11'd500) != (w_p1ScoreNext / 11'd500));
    w_p2Bonus     = w_p2Kill && ((r_p2Score / 11'd500) != (w_p2ScoreNext / 11'd500));
`else
    w_p1Bonus     = 1'b0;
    w_p2Bonus     = 1'b0;
`endif
    w_p1LivesNext = nextLives(r_p1Lives, w_p1Hit, w_p1Bonus);
    w_p2LivesNext = nextLives(r_p2Lives, w_p2Hit, w_p2Bonus);
    w_tankNext    = w_spawn ? (r_tankLeft - 6'd1) : r_tankLeft;
    w_aliveUp     = {1'b0, r_alive} + {6'b0, w_spawn};
    w_aliveDec    = {6'b0, w_p1Kill} + {6'b0, w_p2Kill};
    w_aliveDiff   = w_aliveUp - w_aliveDec;
    w_aliveNext   = (w_aliveUp > w_aliveDec) ? w_aliveDiff[5:0] : 6'd0;
  end

  // Game-over and level-clear decisions look at the post-event values so they land in the
  // same edge as the event that caused them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_level      <= 4'd1;
      r_tankLeft   <= 6'd0;
      r_alive      <= 6'd0;
      r_p1Score    <= 11'd0;
      r_p2Score    <= 11'd0;
      r_p1Lives    <= 4'd0;
      r_p2Lives    <= 4'd0;
      r_gameWon    <= 1'b0;
      r_levelClear <= 1'b0;
      r_delayCnt   <= '0;
    end else begin
      r_levelClear <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAME_OVER: begin
          if (bus.start_i) begin
            r_state    <= ST_PLAY;
            r_level    <= 4'd1;
            r_tankLeft <= TANKS_INIT;
            r_alive    <= 6'd0;
            r_p1Score  <= 11'd0;
            r_p2Score  <= 11'd0;
            r_p1Lives  <= LIVES_INIT;
            r_p2Lives  <= LIVES_INIT;
            r_gameWon  <= 1'b0;
            r_delayCnt <= '0;
          end
        end
        ST_PLAY: begin
          r_p1Score  <= w_p1ScoreNext;
          r_p2Score  <= w_p2ScoreNext;
          r_p1Lives  <= w_p1LivesNext;
          r_p2Lives  <= w_p2LivesNext;
          r_tankLeft <= w_tankNext;
          r_alive    <= w_aliveNext;
          if ((w_p1LivesNext == 4'd0) && (w_p2LivesNext == 4'd0)) begin
            r_state   <= ST_GAME_OVER;
            r_gameWon <= 1'b0;
          end else if ((w_tankNext == 6'd0) && (w_aliveNext == 6'd0)) begin
            r_state      <= ST_LEVEL_CLEAR;
            r_levelClear <= 1'b1;
            r_delayCnt   <= '0;
          end
        end
        ST_LEVEL_CLEAR: begin
          if (r_delayCnt == CNT_LAST) begin
            r_delayCnt <= '0;
            if (r_level == 4'd9) begin
              r_state   <= ST_GAME_OVER;
              r_gameWon <= 1'b1;
            end else begin
              r_state    <= ST_PLAY;
              r_level    <= r_level + 4'd1;
              r_tankLeft <= TANKS_INIT;
            end
          end else begin
            r_delayCnt <= r_delayCnt + CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tank_left_o          = r_tankLeft;
  assign bus.level_o              = r_level;
  assign bus.player_1_score_o     = r_p1Score;
  assign bus.player_2_score_o     = r_p2Score;
  assign bus.player_1_live_left_o = r_p1Lives;
  assign bus.player_2_live_left_o = r_p2Lives;
  assign bus.state_o              = r_state;
  assign bus.game_won_o           = r_gameWon;
  assign bus.level_clear_o        = r_levelClear;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed events push expected outputs into a queue,
// and a monitor compares them one cycle later on the falling edge.
module tb_score_keeper;

`ifdef SCORE_KEEPER_BONUS_LIFE_EN
  localparam int BONUS = 1;
`else
  localparam int BONUS = 0;
`endif

  typedef enum int {F_STATE, F_LEVEL, F_TANK, F_S1, F_S2, F_L1, F_L2, F_WON, F_CLR} field_t;

  typedef struct {
    int     due;
    field_t field;
    int     expVal;
    string  tag;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  exp_t expQ[$];
  int   cycleCount = 0;
  int   passCount  = 0;
  int   checkCount = 0;

  score_keeper_if skIf();

  score_keeper #(
    .START_LIVES    (3),
    .TANKS_PER_LEVEL(20),
    .CLEAR_DELAY    (120)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (skIf)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCount <= cycleCount + 1;

  function automatic int sample(input field_t f);
    case (f)
      F_STATE: return int'(skIf.state_o);
      F_LEVEL: return int'(skIf.level_o);
      F_TANK:  return int'(skIf.tank_left_o);
      F_S1:    return int'(skIf.player_1_score_o);
      F_S2:    return int'(skIf.player_2_score_o);
      F_L1:    return int'(skIf.player_1_live_left_o);
      F_L2:    return int'(skIf.player_2_live_left_o);
      F_WON:   return int'(skIf.game_won_o);
      default: return int'(skIf.level_clear_o);
    endcase
  endfunction

  // Monitor: every falling edge, retire all expectations that have come due.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk_i);
      while ((expQ.size() > 0) && (expQ[0].due <= cycleCount)) begin
        e   = expQ.pop_front();
        act = sample(e.field);
        checkCount++;
        if (act == e.expVal) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", e.tag, act, e.expVal);
      end
    end
  end

  task automatic applyStimulus(input logic start, input logic spawn,
                               input logic k1, input logic [1:0] t1,
                               input logic k2, input logic [1:0] t2,
                               input logic h1, input logic h2);
    skIf.start_i        = start;
    skIf.spawn_i        = spawn;
    skIf.p1_kill_i      = k1;
    skIf.p1_kill_type_i = t1;
    skIf.p2_kill_i      = k2;
    skIf.p2_kill_type_i = t2;
    skIf.p1_hit_i       = h1;
    skIf.p2_hit_i       = h2;
  endtask

  task automatic checkOutput(input string tag, input field_t f, input int v);
    exp_t e;
    e.due    = cycleCount + 1;
    e.field  = f;
    e.expVal = v;
    e.tag    = tag;
    expQ.push_back(e);
  endtask

  task automatic advanceCycle();
    @(negedge clk_i);
    applyStimulus(0, 0, 0, 2'd0, 0, 2'd0, 0, 0);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    @(negedge clk_i);

    $display("[TB] reset values");
    checkOutput("rst_state", F_STATE, 0);
    checkOutput("rst_level", F_LEVEL, 1);
    checkOutput("rst_tank",  F_TANK,  0);
    checkOutput("rst_s1",    F_S1,    0);
    checkOutput("rst_s2",    F_S2,    0);
    checkOutput("rst_l1",    F_L1,    0);
    checkOutput("rst_l2",    F_L2,    0);
    checkOutput("rst_won",   F_WON,   0);
    checkOutput("rst_clr",   F_CLR,   0);
    advanceCycle();
    advanceCycle();
    rst_ni = 1'b1;

    $display("[TB] start and level 1 clear");
    applyStimulus(1, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("start_state", F_STATE, 1);
    checkOutput("start_level", F_LEVEL, 1);
    checkOutput("start_tank",  F_TANK,  20);
    checkOutput("start_l1",    F_L1,    3);
    checkOutput("start_l2",    F_L2,    3);
    checkOutput("start_s1",    F_S1,    0);
    checkOutput("start_s2",    F_S2,    0);
    advanceCycle();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 1, 0, 2'd0, 0, 2'd0, 0, 0);
      if (i == 1) checkOutput("spawn_first", F_TANK, 19);
      if (i == 20) begin
        checkOutput("spawn_last", F_TANK, 0);
        checkOutput("spawn_last_state", F_STATE, 1);
      end
      advanceCycle();
    end
    applyStimulus(0, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("spawn_at_zero", F_TANK, 0);
    advanceCycle();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 0, 1, 2'd3, 0, 2'd0, 0, 0);
      if (i == 13) begin
        checkOutput("kill13_s1", F_S1, 520);
        checkOutput("kill13_l1", F_L1, 3 + BONUS);
      end
      if (i == 19) begin
        checkOutput("kill19_s1",  F_S1,    760);
        checkOutput("kill19_clr", F_CLR,   0);
        checkOutput("kill19_st",  F_STATE, 1);
      end
      if (i == 20) begin
        checkOutput("kill20_s1",  F_S1,    800);
        checkOutput("kill20_clr", F_CLR,   1);
        checkOutput("kill20_st",  F_STATE, 2);
      end
      advanceCycle();
    end
    for (int i = 1; i <= 120; i++) begin
      if (i == 1) begin
        checkOutput("clr_pulse_end", F_CLR,   0);
        checkOutput("clr_state",     F_STATE, 2);
      end
      if (i == 119) begin
        checkOutput("clr_119_state", F_STATE, 2);
        checkOutput("clr_119_level", F_LEVEL, 1);
      end
      if (i == 120) begin
        checkOutput("lvl2_level", F_LEVEL, 2);
        checkOutput("lvl2_tank",  F_TANK,  20);
        checkOutput("lvl2_state", F_STATE, 1);
        checkOutput("lvl2_s1",    F_S1,    800);
      end
      advanceCycle();
    end

    $display("[TB] level 2 events");
    applyStimulus(1, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("start_in_play_s1",    F_S1,    800);
    checkOutput("start_in_play_level", F_LEVEL, 2);
    advanceCycle();
    applyStimulus(0, 0, 1, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("kill_alive0_s1",   F_S1,   810);
    checkOutput("kill_alive0_tank", F_TANK, 20);
    advanceCycle();
    applyStimulus(0, 1, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("lvl2_spawn", F_TANK, 19);
    advanceCycle();
    applyStimulus(0, 0, 1, 2'd0, 1, 2'd2, 0, 0);
    checkOutput("dual_kill_s1", F_S1, 820);
    checkOutput("dual_kill_s2", F_S2, 30);
    advanceCycle();
    for (int i = 1; i <= 19; i++) begin
      applyStimulus(0, 1, 0, 2'd0, 1, 2'd0, 0, 0);
      if (i == 19) begin
        checkOutput("net_spawn_kill_clr", F_CLR,   1);
        checkOutput("net_spawn_kill_st",  F_STATE, 2);
        checkOutput("net_spawn_kill_s2",  F_S2,    220);
      end
      advanceCycle();
    end
    repeat (5) advanceCycle();

    $display("[TB] mid-game reset");
    rst_ni = 1'b0;
    checkOutput("mid_rst_state", F_STATE, 0);
    checkOutput("mid_rst_level", F_LEVEL, 1);
    checkOutput("mid_rst_s1",    F_S1,    0);
    checkOutput("mid_rst_l2",    F_L2,    0);
    checkOutput("mid_rst_clr",   F_CLR,   0);
    advanceCycle();
    rst_ni = 1'b1;
    applyStimulus(0, 1, 1, 2'd3, 0, 2'd0, 1, 0);
    checkOutput("idle_ignore_state", F_STATE, 0);
    checkOutput("idle_ignore_s1",    F_S1,    0);
    checkOutput("idle_ignore_tank",  F_TANK,  0);
    advanceCycle();

    $display("[TB] bonus crossing and hits");
    applyStimulus(1, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("g2_start_l1", F_L1, 3);
    advanceCycle();
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, 0, 1, 2'd3, 0, 2'd0, 0, 0);
      advanceCycle();
    end
    applyStimulus(0, 0, 1, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("s1_490", F_S1, 490);
    checkOutput("l1_pre", F_L1, 3);
    advanceCycle();
    applyStimulus(0, 0, 1, 2'd1, 0, 2'd0, 0, 0);
    checkOutput("s1_510",   F_S1, 510);
    checkOutput("bonus_l1", F_L1, 3 + BONUS);
    advanceCycle();
    for (int i = 1; i <= 3 + BONUS; i++) begin
      applyStimulus(0, 0, 0, 2'd0, 0, 2'd0, 1, 0);
      if (i == 3 + BONUS) begin
        checkOutput("p1_dead_l1",    F_L1,    0);
        checkOutput("p1_dead_state", F_STATE, 1);
      end
      advanceCycle();
    end
    applyStimulus(0, 0, 1, 2'd3, 0, 2'd0, 1, 0);
    checkOutput("dead_kill_s1", F_S1, 510);
    checkOutput("dead_hit_l1",  F_L1, 0);
    advanceCycle();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 2'd0, 0, 2'd0, 0, 1);
      if (i == 2) begin
        checkOutput("p2_hit2_l2", F_L2,    1);
        checkOutput("p2_hit2_st", F_STATE, 1);
      end
      if (i == 3) begin
        checkOutput("gameover_l2",  F_L2,    0);
        checkOutput("gameover_st",  F_STATE, 3);
        checkOutput("gameover_won", F_WON,   0);
      end
      advanceCycle();
    end
    applyStimulus(0, 1, 0, 2'd0, 1, 2'd3, 0, 0);
    checkOutput("go_ignore_s2",   F_S2,    0);
    checkOutput("go_ignore_tank", F_TANK,  20);
    checkOutput("go_ignore_st",   F_STATE, 3);
    checkOutput("go_keep_s1",     F_S1,    510);
    advanceCycle();

    $display("[TB] saturation and full game win");
    applyStimulus(1, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("g3_start_st", F_STATE, 1);
    checkOutput("g3_start_s1", F_S1,    0);
    checkOutput("g3_start_l1", F_L1,    3);
    advanceCycle();
    for (int i = 1; i <= 51; i++) begin
      applyStimulus(0, 0, 1, 2'd3, 0, 2'd0, 0, 0);
      if (i == 51) begin
        checkOutput("s1_2040",    F_S1, 2040);
        checkOutput("l1_bonus4",  F_L1, 3 + 4 * BONUS);
      end
      advanceCycle();
    end
    applyStimulus(0, 0, 1, 2'd3, 0, 2'd0, 0, 0);
    checkOutput("s1_sat", F_S1, 2047);
    advanceCycle();
    applyStimulus(0, 0, 1, 2'd3, 0, 2'd0, 0, 0);
    checkOutput("s1_sat_hold", F_S1, 2047);
    advanceCycle();
    for (int lvl = 1; lvl <= 9; lvl++) begin
      for (int j = 1; j <= 20; j++) begin
        applyStimulus(0, 1, 0, 2'd0, 1, 2'd0, 0, 0);
        if (j == 20) checkOutput($sformatf("lvl%0d_clr", lvl), F_CLR, 1);
        advanceCycle();
      end
      for (int i = 1; i <= 120; i++) begin
        if ((lvl == 9) && (i == 119)) begin
          checkOutput("lvl9_wait_st",  F_STATE, 2);
          checkOutput("lvl9_wait_won", F_WON,   0);
        end
        if (i == 120) begin
          if (lvl < 9) begin
            checkOutput($sformatf("lvl%0d_level", lvl + 1), F_LEVEL, lvl + 1);
            checkOutput($sformatf("lvl%0d_tank", lvl + 1),  F_TANK,  20);
          end else begin
            checkOutput("won_state", F_STATE, 3);
            checkOutput("won_flag",  F_WON,   1);
            checkOutput("won_level", F_LEVEL, 9);
          end
        end
        advanceCycle();
      end
    end
    applyStimulus(0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    checkOutput("won_s2", F_S2, 1800);
    checkOutput("won_l2", F_L2, 3 + 3 * BONUS);
    checkOutput("won_s1", F_S1, 2047);
    advanceCycle();
    applyStimulus(1, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    checkOutput("restart_won",   F_WON,   0);
    checkOutput("restart_level", F_LEVEL, 1);
    checkOutput("restart_s2",    F_S2,    0);
    checkOutput("restart_tank",  F_TANK,  20);
    advanceCycle();
    advanceCycle();

    checkCount++;
    if (skIf.state_o == 2'd1) passCount++;
    else $display("[TB] FAIL final_state: got %0d, expected 1", skIf.state_o);
    checkCount++;
    if (skIf.level_o == 4'd1) passCount++;
    else $display("[TB] FAIL final_level: got %0d, expected 1", skIf.level_o);
    checkCount++;
    if (skIf.tank_left_o == 6'd20) passCount++;
    else $display("[TB] FAIL final_tank: got %0d, expected 20", skIf.tank_left_o);
    checkCount++;
    if (skIf.player_1_live_left_o == 4'd3) passCount++;
    else $display("[TB] FAIL final_l1: got %0d, expected 3", skIf.player_1_live_left_o);
    checkCount++;
    if (skIf.player_2_live_left_o == 4'd3) passCount++;
    else $display("[TB] FAIL final_l2: got %0d, expected 3", skIf.player_2_live_left_o);
    checkCount++;
    if (skIf.player_1_score_o == 11'd0) passCount++;
    else $display("[TB] FAIL final_s1: got %0d, expected 0", skIf.player_1_score_o);

    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkCount++;
      $display("[TB] FAIL %s: never compared, expected %0d", e.tag, e.expVal);
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    if (passCount == checkCount) $display("[TB] PASS");
    else $display("[TB] FAIL %0d checks failed", checkCount - passCount);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter START_LIVES, default 3, lives per player at game start (1..9).
REQ-002 SHALL have parameter TANKS_PER_LEVEL, default 20, enemy reserve per level (1..32).
REQ-003 SHALL have parameter CLEAR_DELAY, default 120, cycles spent in LEVEL_CLEAR (>=1).
REQ-004 SHALL have port clk_i  in  1  sole clock, all state rising-edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start_i  in  1  one-cycle pulse, starts a new game.
REQ-007 SHALL have port spawn_i  in  1  pulse, enemy tank leaves reserve.
REQ-008 SHALL have ports p1_kill_i / p2_kill_i  in  1 each  pulse, player destroyed an enemy.
REQ-009 SHALL have ports p1_kill_type_i / p2_kill_type_i  in  2 each  enemy type of that kill.
REQ-010 SHALL have ports p1_hit_i / p2_hit_i  in  1 each  pulse, player tank destroyed.
REQ-011 SHALL have port tank_left_o  out  6  enemies remaining in reserve.
REQ-012 SHALL have port level_o  out  4  current level, 1..9.
REQ-013 SHALL have ports player_1_score_o / player_2_score_o  out  11 each  scores.
REQ-014 SHALL have ports player_1_live_left_o / player_2_live_left_o  out  4 each  lives.
REQ-015 SHALL have port state_o  out  2  IDLE=0, PLAY=1, LEVEL_CLEAR=2, GAME_OVER=3.
REQ-016 SHALL have ports game_won_o  out  1  level 9 cleared; level_clear_o  out  1  one-cycle pulse.

Function
REQ-017 All outputs SHALL be registered; every input event SHALL be reflected on outputs exactly one cycle after the sampling edge.
REQ-018 start_i in IDLE or GAME_OVER SHALL load level=1, tank_left=TANKS_PER_LEVEL, alive=0, scores=0, lives=START_LIVES, game_won=0, enter PLAY; start_i in PLAY/LEVEL_CLEAR SHALL be ignored.
REQ-019 Event inputs (spawn, kill, hit) SHALL be honoured only in PLAY and ignored in every other state.
REQ-020 spawn_i SHALL decrement tank_left and increment internal 6-bit alive counter; spawn_i with tank_left=0 SHALL be ignored.
REQ-021 A kill SHALL add type-dependent points (0->10, 1->20, 2->30, 3->40) to that player's score, saturating at 2047, and decrement alive, flooring at 0.
REQ-022 Simultaneous p1 and p2 kills SHALL credit both players and decrement alive by 2 (floor 0); simultaneous spawn and kill SHALL apply net change.
REQ-023 A player with 0 lives SHALL have kills and hits ignored; a hit SHALL decrement that player's lives by 1.
REQ-024 When both lives reach 0, the next state SHALL be GAME_OVER with game_won_o=0; this SHALL take priority over level clear in the same cycle.
REQ-025 When tank_left=0 and alive=0 in PLAY, the block SHALL pulse level_clear_o for one cycle and enter LEVEL_CLEAR.
REQ-026 LEVEL_CLEAR SHALL count CLEAR_DELAY cycles, then: level<9 -> level+1, tank_left=TANKS_PER_LEVEL, back to PLAY; level=9 -> GAME_OVER with game_won_o=1, level held at 9.
REQ-027 Scores and lives SHALL persist across levels and in GAME_OVER until the next start_i.

Reset
REQ-028 Assertion of rst_ni SHALL immediately force state IDLE, level_o=1, tank_left_o=0, scores=0, lives=0, game_won_o=0, level_clear_o=0, delay counter=0, alive=0.
REQ-029 Reset mid-game SHALL discard all progress; only start_i resumes play.

Configuration
REQ-030 With SCORE_KEEPER_BONUS_LIFE_EN defined, a kill that makes a player's score cross a multiple of 500 (old/500 != new/500) SHALL grant +1 life, capped at 9, in the same update.
REQ-031 Without SCORE_KEEPER_BONUS_LIFE_EN, lives SHALL only decrease within a game.

Verification
REQ-032 Reset then start_i -> state_o=1, level_o=1, tank_left_o=20, lives 3/3, scores 0/0.
REQ-033 Spawn 20 times, p1 kills type 3 x20 -> tank_left_o=0, p1 score 800, level_clear_o one pulse, 120 cycles later level_o=2, tank_left_o=20.
REQ-034 Same-cycle p1_kill type 0 and p2_kill type 2 with alive=1 -> p1 +10, p2 +30, alive 0.
REQ-035 p1_hit x3 then p2_hit x3 -> lives 0/0, state_o=3, game_won_o=0; further kills ignored.
REQ-036 p1 score 490, kill type 1 -> 510; lives 4 with SCORE_KEEPER_BONUS_LIFE_EN, 3 without.
REQ-037 Clear level 9 -> state_o=3, game_won_o=1, level_o=9; score at 2040 plus type 3 kill -> 2047.
